// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, control-word layout,
// CCR bit positions, forwarding select codes and interrupt FSM encoding.
package alu_pkg;

    localparam int DATA_W = 16;

    localparam int EX_OP_LSB  = 0;
    localparam int EX_OP_MSB  = 3;
    localparam int EX_IMM_BIT = 4;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;

    localparam logic [1:0] SEL_BUF = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_NOT  = 4'd6,
        OP_INC  = 4'd7,
        OP_DEC  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_SETC = 4'd11,
        OP_CLRC = 4'd12
    } alu_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SAVED = 1'b1
    } int_state_e;

    // Select code 3 is unused and falls back to the decode-buffer value.
    function automatic logic [DATA_W-1:0] selectOperand(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] bufVal,
        input logic [DATA_W-1:0] memVal,
        input logic [DATA_W-1:0] wbVal
    );
        case (sel)
            SEL_MEM: selectOperand = memVal;
            SEL_WB:  selectOperand = wbVal;
            default: selectOperand = bufVal;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: computes the result and the would-be CCR value.
// Shifter is built only when ALU_SHIFT_EN is defined.
module alu_core
    import alu_pkg::*;
(
    input  alu_op_e            i_op,
    input  logic [DATA_W-1:0]  i_src1,
    input  logic [DATA_W-1:0]  i_src2,
    input  logic               i_c_in,
    input  logic               i_n_in,
    input  logic               i_z_in,
    output logic [DATA_W-1:0]  o_result,
    output logic [2:0]         o_flags,
    output logic               o_flag_upd
);

    logic [DATA_W:0] w_wide;
    logic            w_carry;
    logic            w_keep_zn;

    always_comb begin
        w_wide     = {1'b0, i_src1};
        w_carry    = i_c_in;
        w_keep_zn  = 1'b0;
        o_flag_upd = 1'b1;
        o_result   = i_src1;
        case (i_op)
            OP_ADD: begin
                w_wide   = {1'b0, i_src1} + {1'b0, i_src2};
                w_carry  = w_wide[DATA_W];
                o_result = w_wide[DATA_W-1:0];
            end
            OP_SUB: begin
                w_wide   = {1'b0, i_src1} - {1'b0, i_src2};
                w_carry  = w_wide[DATA_W];
                o_result = w_wide[DATA_W-1:0];
            end
            OP_AND: o_result = i_src1 & i_src2;
            OP_OR:  o_result = i_src1 | i_src2;
            OP_NOT: o_result = ~i_src1;
            OP_INC: begin
                w_wide   = {1'b0, i_src1} + 17'd1;
                w_carry  = w_wide[DATA_W];
                o_result = w_wide[DATA_W-1:0];
            end
            OP_DEC: begin
                w_wide   = {1'b0, i_src1} - 17'd1;
                w_carry  = w_wide[DATA_W];
                o_result = w_wide[DATA_W-1:0];
            end
`ifdef ALU_SHIFT_EN
            // The extra 17th bit catches the last bit shifted out on either side.
            OP_SHL: begin
                w_wide   = {1'b0, i_src1} << i_src2[3:0];
                o_result = w_wide[DATA_W-1:0];
                if (i_src2[3:0] != 4'd0) w_carry = w_wide[DATA_W];
            end
            OP_SHR: begin
                w_wide   = {i_src1, 1'b0} >> i_src2[3:0];
                o_result = w_wide[DATA_W:1];
                if (i_src2[3:0] != 4'd0) w_carry = w_wide[0];
            end
`else
            OP_SHL, OP_SHR: o_flag_upd = 1'b0;
`endif
            OP_SETC: begin
                w_carry   = 1'b1;
                w_keep_zn = 1'b1;
            end
            OP_CLRC: begin
                w_carry   = 1'b0;
                w_keep_zn = 1'b1;
            end
            default: ;
        endcase
        o_flags[CCR_C] = w_carry;
        o_flags[CCR_N] = w_keep_zn ? i_n_in : o_result[DATA_W-1];
        o_flags[CCR_Z] = w_keep_zn ? i_z_in : (o_result == '0);
    end

endmodule

// File: rtl/alu_stage.sv
// Execute stage: operand forwarding muxes, ALU, CCR, output port and the
// single-level interrupt flag save/restore FSM. Shifts need ALU_SHIFT_EN.
module alu_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [13:0]        i_Ex,
    input  logic [DATA_W-1:0]  i_read_data1,
    input  logic [DATA_W-1:0]  i_read_data2,
    input  logic [DATA_W-1:0]  i_immd,
    input  logic [DATA_W-1:0]  i_fwd_mem,
    input  logic [DATA_W-1:0]  i_fwd_wb,
    input  logic [1:0]         i_sel1,
    input  logic [1:0]         i_sel2,
    input  logic               i_chg_flag,
    input  logic               i_output_write,
    input  logic               i_INT,
    input  logic               i_rti,
    output logic [DATA_W-1:0]  o_result,
    output logic [2:0]         o_flags,
    output logic [DATA_W-1:0]  o_out_port,
    output logic               o_int_active
);

    alu_op_e           w_op;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic [2:0]        w_flags;
    logic              w_flag_upd;
    logic [2:0]        w_ccr_after;
    logic              w_unused;

    logic [2:0]        r_ccr;
    logic [2:0]        r_shadow;
    logic [DATA_W-1:0] r_out_port;
    int_state_e        r_state;
    int_state_e        w_state_next;

    assign w_unused = ^i_Ex[13:5];
    assign w_op     = alu_op_e'(i_Ex[EX_OP_MSB:EX_OP_LSB]);
    assign w_src1   = selectOperand(i_sel1, i_read_data1, i_fwd_mem, i_fwd_wb);
    assign w_src2   = i_Ex[EX_IMM_BIT] ? i_immd
                                       : selectOperand(i_sel2, i_read_data2, i_fwd_mem, i_fwd_wb);

    alu_core u_core (
        .i_op       (w_op),
        .i_src1     (w_src1),
        .i_src2     (w_src2),
        .i_c_in     (r_ccr[CCR_C]),
        .i_n_in     (r_ccr[CCR_N]),
        .i_z_in     (r_ccr[CCR_Z]),
        .o_result   (o_result),
        .o_flags    (w_flags),
        .o_flag_upd (w_flag_upd)
    );

    // CCR value this edge would produce ignoring a restore; also what INT saves.
    assign w_ccr_after = (i_chg_flag && w_flag_upd) ? w_flags : r_ccr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else if (enable) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_INT) w_state_next = ST_SAVED;
            ST_SAVED: if (i_rti) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_int_active = (r_state == ST_SAVED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ccr      <= '0;
            r_shadow   <= '0;
            r_out_port <= '0;
        end else if (enable) begin
            if (r_state == ST_SAVED && i_rti) begin
                r_ccr <= r_shadow;
            end else begin
                r_ccr <= w_ccr_after;
            end
            if (r_state == ST_IDLE && i_INT) begin
                r_shadow <= w_ccr_after;
            end
            if (i_output_write) begin
                r_out_port <= w_src1;
            end
        end
    end

    assign o_flags    = r_ccr;
    assign o_out_port = r_out_port;

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: a behavioural model predicts each edge and
// a scoreboard queue holds the expected registered outputs until after the edge.
module tb_alu_stage;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [13:0] ex;
    logic [15:0] rd1, rd2, immd, fwdMem, fwdWb;
    logic [1:0]  sel1, sel2;
    logic        chgFlag, outputWrite, intReq, rti;
    logic [15:0] result;
    logic [2:0]  flags;
    logic [15:0] outPort;
    logic        intActive;

    typedef struct {
        string       tag;
        logic [2:0]  flags;
        logic [15:0] outPort;
        logic        active;
    } expect_t;

    expect_t     sbQueue[$];
    int          testsRun;
    int          testsFailed;
    logic [2:0]  mCcr;
    logic [2:0]  mShadow;
    logic        mSaved;
    logic [15:0] mOut;

    alu_stage dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .i_Ex           (ex),
        .i_read_data1   (rd1),
        .i_read_data2   (rd2),
        .i_immd         (immd),
        .i_fwd_mem      (fwdMem),
        .i_fwd_wb       (fwdWb),
        .i_sel1         (sel1),
        .i_sel2         (sel2),
        .i_chg_flag     (chgFlag),
        .i_output_write (outputWrite),
        .i_INT          (intReq),
        .i_rti          (rti),
        .o_result       (result),
        .o_flags        (flags),
        .o_out_port     (outPort),
        .o_int_active   (intActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] bufVal,
                                         input logic [15:0] memVal, input logic [15:0] wbVal);
        if (s == 2'd1) return memVal;
        if (s == 2'd2) return wbVal;
        return bufVal;
    endfunction

    function automatic void modelAlu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic [2:0] ccr, output logic [15:0] res,
                                     output logic [2:0] nf, output logic upd);
        int   s;
        int   n;
        logic c;
        logic keepZn;
        res    = a;
        c      = ccr[2];
        keepZn = 1'b0;
        upd    = 1'b1;
        n      = int'(b[3:0]);
        s      = 0;
        case (op)
            4'd2: begin s = int'(a) + int'(b); res = s[15:0]; c = (s > 65535); end
            4'd3: begin res = a - b; c = (a < b); end
            4'd4: res = a & b;
            4'd5: res = a | b;
            4'd6: res = ~a;
            4'd7: begin res = a + 16'd1; c = (a == 16'hFFFF); end
            4'd8: begin res = a - 16'd1; c = (a == 16'h0000); end
`ifdef ALU_SHIFT_EN
            4'd9:  if (n != 0) begin res = a << n; c = a[16-n]; end
            4'd10: if (n != 0) begin res = a >> n; c = a[n-1]; end
`else
            4'd9, 4'd10: upd = 1'b0;
`endif
            4'd11: begin c = 1'b1; keepZn = 1'b1; end
            4'd12: begin c = 1'b0; keepZn = 1'b1; end
            default: ;
        endcase
        nf = keepZn ? {c, ccr[1:0]} : {c, res[15], (res == 16'h0000)};
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic applyStimulus(input string tag, input logic [3:0] op, input logic useImm,
                                 input logic [1:0] s1, input logic [1:0] s2, input logic en,
                                 input logic chg, input logic ow, input logic ir, input logic rt);
        logic [15:0] a, b, res;
        logic [2:0]  nf, after;
        logic        upd;
        expect_t     e;
        ex          = {9'($urandom_range(0, 511)), useImm, op};
        sel1        = s1;
        sel2        = s2;
        enable      = en;
        chgFlag     = chg;
        outputWrite = ow;
        intReq      = ir;
        rti         = rt;
        a = pick(s1, rd1, fwdMem, fwdWb);
        b = useImm ? immd : pick(s2, rd2, fwdMem, fwdWb);
        modelAlu(op, a, b, mCcr, res, nf, upd);
        #1;
        checkOutput({tag, ".result"}, result, res);
        after = (chg && upd) ? nf : mCcr;
        if (en) begin
            if (mSaved && rt) begin
                mCcr   = mShadow;
                mSaved = 1'b0;
            end else begin
                mCcr = after;
                if (!mSaved && ir) begin
                    mShadow = after;
                    mSaved  = 1'b1;
                end
            end
            if (ow) mOut = a;
        end
        e.tag = tag; e.flags = mCcr; e.outPort = mOut; e.active = mSaved;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        e = sbQueue.pop_front();
        checkOutput({e.tag, ".flags"}, {13'd0, flags}, {13'd0, e.flags});
        checkOutput({e.tag, ".outPort"}, outPort, e.outPort);
        checkOutput({e.tag, ".intActive"}, {15'd0, intActive}, {15'd0, e.active});
        @(negedge clk);
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        mCcr = 3'b000; mShadow = 3'b000; mSaved = 1'b0; mOut = 16'h0000;
        rst = 1'b0; enable = 1'b0; ex = '0;
        rd1 = '0; rd2 = '0; immd = '0; fwdMem = '0; fwdWb = '0;
        sel1 = '0; sel2 = '0; chgFlag = 0; outputWrite = 0; intReq = 0; rti = 0;
        #2;
        checkOutput("reset.flags", {13'd0, flags}, 16'h0000);
        checkOutput("reset.outPort", outPort, 16'h0000);
        checkOutput("reset.intActive", {15'd0, intActive}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        rd1 = 16'hFFFF; rd2 = 16'h0001;
        applyStimulus("add_wrap", 4'd2, 0, 2'd0, 2'd0, 1, 1, 0, 0, 0);
        checkOutput("add_wrap.ccr", {13'd0, flags}, 16'h0005);
        rd1 = 16'h0003; fwdMem = 16'h0005; rd2 = 16'h7777;
        applyStimulus("sub_fwdmem", 4'd3, 0, 2'd0, 2'd1, 1, 1, 0, 0, 0);
        checkOutput("sub_fwdmem.ccr", {13'd0, flags}, 16'h0006);

        rd1 = 16'hFFFF; rd2 = 16'h0001;
        applyStimulus("set101", 4'd2, 0, 2'd0, 2'd0, 1, 1, 0, 0, 0);
        applyStimulus("int_enter", 4'd0, 0, 2'd0, 2'd0, 1, 0, 0, 1, 0);
        rd1 = 16'h0001; rd2 = 16'h0001;
        applyStimulus("add_in_isr", 4'd2, 0, 2'd0, 2'd0, 1, 1, 0, 0, 0);
        applyStimulus("int_nested", 4'd0, 0, 2'd0, 2'd0, 1, 0, 0, 1, 0);
        rd1 = 16'h0000;
        applyStimulus("rti_restore", 4'd0, 0, 2'd0, 2'd0, 1, 1, 0, 0, 1);
        checkOutput("rti_restore.ccr", {13'd0, flags}, 16'h0005);
        applyStimulus("rti_idle", 4'd0, 0, 2'd0, 2'd0, 1, 0, 0, 0, 1);

        rd1 = 16'h8001; immd = 16'h0001;
        applyStimulus("shl_1", 4'd9, 1, 2'd0, 2'd0, 1, 1, 0, 0, 0);
        immd = 16'h0004;
        applyStimulus("shr_4", 4'd10, 1, 2'd0, 2'd0, 1, 1, 0, 0, 0);
        rd1 = 16'h8001; immd = 16'h0000;
        applyStimulus("shl_0", 4'd9, 1, 2'd0, 2'd0, 1, 1, 0, 0, 0);

        fwdWb = 16'h00F0; rd2 = 16'h0F0F;
        applyStimulus("or_wb", 4'd5, 0, 2'd2, 2'd0, 1, 1, 0, 0, 0);
        rd1 = 16'h1234; fwdMem = 16'hDEAD; fwdWb = 16'hBEEF;
        applyStimulus("sel3_mov", 4'd1, 0, 2'd3, 2'd3, 1, 1, 0, 0, 0);
        rd1 = 16'h0000;
        applyStimulus("frozen", 4'd0, 0, 2'd0, 2'd0, 0, 1, 1, 1, 0);

        rd1 = 16'h1234;
        applyStimulus("out_disabled", 4'd0, 0, 2'd0, 2'd0, 0, 0, 1, 0, 0);
        applyStimulus("out_enabled", 4'd0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 0);
        checkOutput("out_enabled.port", outPort, 16'h1234);

        rd1 = 16'h0000;
        applyStimulus("int_with_chg", 4'd8, 0, 2'd0, 2'd0, 1, 1, 0, 1, 0);
        applyStimulus("clrc_in_isr", 4'd12, 0, 2'd0, 2'd0, 1, 1, 0, 0, 0);
        applyStimulus("rti_2", 4'd0, 0, 2'd0, 2'd0, 1, 0, 0, 0, 1);

        for (int i = 0; i < 60; i++) begin
            rd1 = 16'($urandom); rd2 = 16'($urandom); immd = 16'($urandom);
            fwdMem = 16'($urandom); fwdWb = 16'($urandom);
            applyStimulus("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 5) == 0));
        end

        if (mSaved) applyStimulus("pre_rti", 4'd0, 0, 2'd0, 2'd0, 1, 0, 0, 0, 1);
        rd1 = 16'hABCD;
        applyStimulus("pre_setc", 4'd11, 0, 2'd0, 2'd0, 1, 1, 1, 0, 0);
        applyStimulus("pre_int", 4'd0, 0, 2'd0, 2'd0, 1, 0, 0, 1, 0);
        intReq = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_rst.flags", {13'd0, flags}, 16'h0000);
        checkOutput("async_rst.outPort", outPort, 16'h0000);
        checkOutput("async_rst.intActive", {15'd0, intActive}, 16'h0000);
        mCcr = 3'b000; mShadow = 3'b000; mSaved = 1'b0; mOut = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("rti_after_rst", 4'd0, 0, 2'd0, 2'd0, 1, 0, 0, 0, 1);
        checkOutput("rti_after_rst.ccr", {13'd0, flags}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
